// File: rtl/instr_encoder.sv
// Encodes one MIPS instruction per accepted request and queues {word, address} pairs in a
// two-entry FIFO for a downstream memory writer.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   base_load, base_addr  load the enqueue address (low two bits ignored)
//   in_valid/in_ready     request handshake; in_ready depends only on registered state
//   kind, rs, rt, rd,
//   shamt, funct, imm,
//   target                instruction fields of the request
//   out_valid/out_ready   output handshake; out_word/out_addr show the FIFO head
//   err, err_cnt          sticky reject flag and saturating reject counter
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [31:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] KindRtype = 4'd0;
    localparam logic [3:0] KindLw    = 4'd1;
    localparam logic [3:0] KindSw    = 4'd2;
    localparam logic [3:0] KindJ     = 4'd3;
    localparam logic [3:0] KindBeq   = 4'd4;
    localparam logic [3:0] KindBne   = 4'd5;
    localparam logic [3:0] KindAddi  = 4'd6;
    localparam logic [3:0] KindLui   = 4'd7;
    localparam logic [3:0] KindOri   = 4'd8;
    localparam logic [3:0] KindSlti  = 4'd9;
    localparam logic [3:0] KindAndi  = 4'd10;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;

    localparam logic [5:0] FunctSll = 6'b000000;
    localparam logic [5:0] FunctSrl = 6'b000010;

    logic [31:0] enq_addr_q, enq_addr_d;
    logic [63:0] mem_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        err_q;
    logic [7:0]  err_cnt_q;

    logic [31:0] next_pc;
    logic [31:0] diff;
    logic        br_ok;
    logic [31:0] word;
    logic        legal;
    logic        in_fire, out_fire, push, reject;
    logic [4:0]  rs_eff, shamt_eff;

    assign next_pc = enq_addr_q + 32'd4;
    assign diff    = target - next_pc;
    // enq_addr is always word aligned, so diff[1:0] == 0 is exactly target[1:0] == 0.
    // The range [-131072, +131068] is an 18-bit signed value: bits 31..17 all equal.
    assign br_ok   = (diff[1:0] == 2'b00) &&
                     ((diff[31:17] == 15'h0000) || (diff[31:17] == 15'h7fff));

    always_comb begin
        word      = '0;
        legal     = 1'b1;
        rs_eff    = rs;
        shamt_eff = shamt;
        case (kind)
            KindRtype: begin
                // Shifts by constant have no rs; everything else has no shamt.
                if (funct == FunctSll || funct == FunctSrl) begin
                    rs_eff = '0;
                end else begin
                    shamt_eff = '0;
                end
                word = {OpRtype, rs_eff, rt, rd, shamt_eff, funct};
            end
            KindLw:   word = {OpLw, rs, rt, imm};
            KindSw:   word = {OpSw, rs, rt, imm};
            KindAddi: word = {OpAddi, rs, rt, imm};
            KindOri:  word = {OpOri, rs, rt, imm};
            KindSlti: word = {OpSlti, rs, rt, imm};
            KindAndi: word = {OpAndi, rs, rt, imm};
            KindLui:  word = {OpLui, 5'b00000, rt, imm};
            KindBeq: begin
                word  = {OpBeq, rs, rt, diff[17:2]};
                legal = br_ok;
            end
            KindBne: begin
                word  = {OpBne, rs, rt, diff[17:2]};
                legal = br_ok;
            end
            KindJ: begin
                word  = {OpJ, target[27:2]};
                legal = (target[1:0] == 2'b00) && (target[31:28] == next_pc[31:28]);
            end
            default: legal = 1'b0;
        endcase
    end

    // in_ready is a function of the registered occupancy only, so a pop in the same cycle
    // never opens a slot (no bypass).
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign push      = in_fire && legal;
    assign reject    = in_fire && !legal;

    always_comb begin
        count_d = count_q;
        if (push && !out_fire) begin
            count_d = count_q + 2'd1;
        end else if (!push && out_fire) begin
            count_d = count_q - 2'd1;
        end
    end

    // base_load takes priority: a request in the same cycle still uses the old address.
    always_comb begin
        enq_addr_d = enq_addr_q;
        if (base_load) begin
            enq_addr_d = base_addr & 32'hffff_fffc;
        end else if (push) begin
            enq_addr_d = next_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enq_addr_q <= '0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            enq_addr_q <= enq_addr_d;
            count_q    <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {word, enq_addr_q};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (out_fire) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (reject) begin
                err_q <= 1'b1;
                if (err_cnt_q != 8'hff) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign out_word = mem_q[rd_ptr_q][63:32];
    assign out_addr = mem_q[rd_ptr_q][31:0];
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a table of requests with hand-encoded expected
// words, a scoreboard queue of {word, address} filled on input transfers and drained on
// output transfers, and hand-written sequences for back-pressure, saturation and reset.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        base_load, in_valid, in_ready, out_valid, out_ready, err;
    logic [31:0] base_addr, target, out_word, out_addr;
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .base_load (base_load),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kind      (kind),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm       (imm),
        .target    (target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        logic        valid;
        logic        bl;
        logic [31:0] ba;
        logic [3:0]  kind;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [31:0] target;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[$];
    vec_t        nop;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_addr = '0;
    int          m_err_cnt = 0;

    function automatic vec_t mk(input logic [3:0] k, input logic [4:0] rs_, input logic [4:0] rt_,
                                input logic [4:0] rd_, input logic [4:0] sh_,
                                input logic [5:0] fn, input logic [15:0] im,
                                input logic [31:0] tg, input logic lg, input logic [31:0] w);
        vec_t v;
        v.valid = 1'b1; v.bl = 1'b0; v.ba = '0;
        v.kind = k; v.rs = rs_; v.rt = rt_; v.rd = rd_; v.shamt = sh_; v.funct = fn;
        v.imm = im; v.target = tg; v.legal = lg; v.word = w;
        return v;
    endfunction

    function automatic vec_t mk_bl(input logic [31:0] a);
        vec_t v;
        v = mk(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'd0, 1'b0, 32'd0);
        v.valid = 1'b0; v.bl = 1'b1; v.ba = a;
        return v;
    endfunction

    function automatic vec_t mk_addi(input logic [15:0] im);
        return mk(4'd6, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, im, 32'd0, 1'b1, 32'h2001_0000 | 32'(im));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = v.valid; base_load = v.bl; base_addr = v.ba; kind = v.kind;
        rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.shamt; funct = v.funct;
        imm = v.imm; target = v.target;
    endtask

    // Called just after a falling edge; evaluates the handshakes that the next rising edge
    // will commit, updates the model, then advances to the next falling edge.
    task automatic cycle(input vec_t v, output logic fired);
        #1;
        fired = 1'b0;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got word 0x%08h, expected none", out_word);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_word", out_word, e.word);
                chk("out_addr", out_addr, e.addr);
            end
        end
        if (in_valid && in_ready) begin
            fired = 1'b1;
            if (v.legal) begin
                sb.push_back('{word: v.word, addr: m_addr});
                if (!v.bl) m_addr = m_addr + 32'd4;
            end else if (m_err_cnt < 255) begin
                m_err_cnt++;
            end
        end
        if (v.bl) m_addr = v.ba & 32'hffff_fffc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input vec_t v);
        logic fired;
        int   n;
        n = 0;
        drive(v);
        do begin
            cycle(v, fired);
            n++;
        end while (!fired && v.valid && n < 20);
        if (v.valid && !fired) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", n);
        end
        drive(nop);
    endtask

    task automatic drain();
        logic f;
        int   n;
        n = 0;
        drive(nop);
        while (sb.size() != 0 && n < 20) begin
            cycle(nop, f);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset();
        drive(nop);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        reset = 1'b0;
        sb.delete();
        m_addr = '0;
        m_err_cnt = 0;
    endtask

    initial begin
        logic f;
        int   n_fired;
        logic saw_valid;
        vec_t v;

        nop = mk(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'd0, 1'b0, 32'd0);
        nop.valid = 1'b0;
        drive(nop);
        out_ready = 1'b1;

        //          kind   rs     rt     rd     sh     funct  imm        target        ok word
        tbl.push_back(mk(4'd0, 5'd1, 5'd2, 5'd3, 5'd7, 6'h20, 16'h0, 32'h0, 1, 32'h0022_1820));
        tbl.push_back(mk(4'd0, 5'd5, 5'd2, 5'd4, 5'd3, 6'h00, 16'h0, 32'h0, 1, 32'h0002_20c0));
        tbl.push_back(mk(4'd7, 5'd9, 5'd8, 5'd0, 5'd0, 6'h0, 16'h1234, 32'h0, 1, 32'h3c08_1234));
        tbl.push_back(mk(4'd0, 5'd3, 5'd4, 5'd5, 5'd31, 6'h02, 16'h0, 32'h0, 1, 32'h0004_2fc2));
        tbl.push_back(mk(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hfffc, 32'h0, 1, 32'h8c22_fffc));
        tbl.push_back(mk(4'd2, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0008, 32'h0, 1, 32'hac64_0008));
        tbl.push_back(mk(4'd6, 5'd5, 5'd6, 5'd0, 5'd0, 6'h0, 16'h8000, 32'h0, 1, 32'h20a6_8000));
        tbl.push_back(mk(4'd8, 5'd7, 5'd8, 5'd0, 5'd0, 6'h0, 16'h00ff, 32'h0, 1, 32'h34e8_00ff));
        tbl.push_back(mk(4'd9, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0001, 32'h0, 1, 32'h2821_0001));
        tbl.push_back(mk(4'd10, 5'd31, 5'd31, 5'd0, 5'd0, 6'h0, 16'hffff, 32'h0, 1, 32'h33ff_ffff));
        tbl.push_back(mk(4'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0000_1000, 1, 32'h0800_0400));
        tbl.push_back(mk(4'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h1000_0000, 0, 32'h0));
        tbl.push_back(mk(4'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0000_1002, 0, 32'h0));
        tbl.push_back(mk(4'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0002_002c, 1, 32'h1000_7fff));
        tbl.push_back(mk(4'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0002_0034, 0, 32'h0));
        tbl.push_back(mk(4'd5, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0, 32'hfffe_0034, 1, 32'h1443_8000));
        tbl.push_back(mk(4'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'hfffe_0034, 0, 32'h0));
        tbl.push_back(mk(4'd11, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0, 0, 32'h0));
        tbl.push_back(mk(4'd6, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0005, 32'h0, 1, 32'h2001_0005));
        // J across a 256 MB region boundary is judged against enq_addr + 4.
        tbl.push_back(mk_bl(32'h0fff_fffc));
        tbl.push_back(mk(4'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h1000_0100, 1, 32'h0800_0040));
        tbl.push_back(mk(4'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0fff_fff0, 0, 32'h0));
        tbl.push_back(mk_bl(32'h0000_0103));
        tbl.push_back(mk(4'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0000_00f0, 1, 32'h1022_fffb));
        tbl.push_back(mk(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0000_0102, 0, 32'h0));
        v = mk(4'd6, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0007, 32'h0, 1, 32'h2022_0007);
        v.bl = 1'b1; v.ba = 32'h0000_2000;
        tbl.push_back(v);
        tbl.push_back(mk(4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0, 1, 32'h3400_0000));

        // Table pass with the writer always ready.
        do_reset();
        foreach (tbl[i]) send(tbl[i]);
        drain();
        chk("tbl_err", 32'(err), 32'(m_err_cnt != 0));
        chk("tbl_err_cnt", 32'(err_cnt), 32'(m_err_cnt));

        // Back-pressure: two accepts fill the FIFO, a pop in the same cycle does not bypass.
        do_reset();
        out_ready = 1'b0;
        send(mk_addi(16'h0001));
        send(mk_addi(16'h0002));
        drive(mk_addi(16'h0003));
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_head_word", out_word, 32'h2001_0001);
        out_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        cycle(mk_addi(16'h0003), f);
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        send(mk_addi(16'h0003));
        drain();

        // 300 illegal kinds: all consumed, counter saturates, nothing enqueued.
        do_reset();
        v = mk(4'd15, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 32'h0, 0, 32'h0);
        drive(v);
        n_fired = 0;
        saw_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle(v, f);
            if (f) n_fired++;
            if (out_valid) saw_valid = 1'b1;
        end
        drive(nop);
        chk("illegal_accepts", 32'(n_fired), 32'd300);
        chk("illegal_out_valid", 32'(saw_valid), 32'd0);
        chk("sat_err_cnt", 32'(err_cnt), 32'(m_err_cnt));
        chk("sat_err_cnt_255", 32'(err_cnt), 32'd255);
        chk("sat_err", 32'(err), 32'd1);

        // Address wrap, then asynchronous reset with a word queued.
        do_reset();
        send(mk_bl(32'hffff_fffc));
        send(mk_addi(16'h0007));
        send(mk_addi(16'h0008));
        drain();
        out_ready = 1'b0;
        send(mk_addi(16'h0009));
        chk("queued_out_valid", 32'(out_valid), 32'd1);
        chk("queued_out_addr", out_addr, 32'h0000_0004);
        #2;
        reset = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_out_word", out_word, 32'd0);
        drive(mk_addi(16'h000a));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(nop);
        sb.delete();
        m_addr = '0;
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send(mk_addi(16'h000b));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 base_load  in  1  pulse: set enqueue address to base_addr.
REQ-004 base_addr  in  32  program start byte address; bits[1:0] ignored (treated 0).
REQ-005 in_valid  in  1  request carries one instruction to encode.
REQ-006 in_ready  out  1  encoder can accept; registered, independent of out_ready in the same cycle.
REQ-007 kind  in  4  0 RTYPE, 1 LW, 2 SW, 3 J, 4 BEQ, 5 BNE, 6 ADDI, 7 LUI, 8 ORI, 9 SLTI, 10 ANDI, 11-15 illegal.
REQ-008 rs, rt, rd, shamt  in  5 each  register and shift fields.
REQ-009 funct  in  6  R-type function code.
REQ-010 imm  in  16  immediate for I-type loads, stores and ALU ops.
REQ-011 target  in  32  branch/jump destination byte address.
REQ-012 out_valid  out  1  encoded word available.
REQ-013 out_ready  in  1  memory writer accepts word.
REQ-014 out_word  out  32  encoded MIPS instruction.
REQ-015 out_addr  out  32  byte address assigned to out_word.
REQ-016 err  out  1  sticky: at least one request rejected.
REQ-017 err_cnt  out  8  rejected-request count, saturates at 255.

Function
REQ-018 Input transfer on in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-019 Two-entry FIFO holds {out_word, out_addr}; in_ready = (FIFO not full); out_valid = (FIFO not empty); the head entry drives out_word and out_addr.
REQ-020 Latency: an accepted word appears on out_valid in the following cycle at the earliest; FIFO order is preserved.
REQ-021 Full FIFO with a simultaneous pop: in_ready stays 0 that cycle; no bypass.
REQ-022 enq_addr (32 bit) is the address of each accepted valid request; it increments by 4 per accepted legal word and wraps modulo 2^32.
REQ-023 Opcodes: RTYPE 000000, LW 100011, SW 101011, J 000010, BEQ 000100, BNE 000101, ADDI 001000, LUI 001111, ORI 001101, SLTI 001010, ANDI 001100.
REQ-024 RTYPE word = {000000, rs, rt, rd, shamt, funct}.
REQ-025 RTYPE exception: for funct 000000 (SLL) or 000010 (SRL), the rs field is forced to 0.
REQ-026 RTYPE exception: for every other funct, the shamt field is forced to 0.
REQ-027 LW/SW/ADDI/ORI/SLTI/ANDI word = {op, rs, rt, imm}.
REQ-028 LUI word = {op, 00000, rt, imm}.
REQ-029 BEQ/BNE: diff = target - (enq_addr + 4), computed as a 32-bit signed value.
REQ-030 BEQ/BNE word = {op, rs, rt, diff[17:2]}.
REQ-031 BEQ/BNE are illegal if target[1:0] != 0.
REQ-032 BEQ/BNE are illegal if diff lies outside [-131072, +131068].
REQ-033 J word = {op, target[27:2]}.
REQ-034 J is illegal if target[1:0] != 0.
REQ-035 J is illegal if target[31:28] != (enq_addr + 4)[31:28].
REQ-036 Handling of an illegal request (kind 11-15, or failing REQ-031/032/034/035) on an input transfer: consumed, not enqueued, enq_addr unchanged, err set, err_cnt incremented (saturating).
REQ-037 base_load with an input transfer in the same cycle: the request is encoded at the old enq_addr, then enq_addr takes base_addr; base_load wins over the increment.
REQ-038 base_load does not alter FIFO contents or queued addresses.

Reset
REQ-039 On reset: FIFO emptied, out_valid 0, in_ready 1, out_word 0, out_addr 0, enq_addr 0, err 0, err_cnt 0.
REQ-040 Reset mid-transfer discards all queued words; no transfer occurs while reset is high.

Verification
REQ-041 Reset; enqueue RTYPE rs=1 rt=2 rd=3 funct=100000 shamt=7, out_ready=1 -> out_word 0x00221820, out_addr 0x0, next word at 0x4.
REQ-042 SLL rs=5 rt=2 rd=4 shamt=3; then LUI rs=9 rt=8 imm=0x1234 -> 0x000220C0, then 0x3C081234.
REQ-043 base_load base_addr=0x100; BEQ rs=1 rt=2 target=0xF0 -> out_addr 0x100, word 0x1022FFFB; BNE target=0x102 -> rejected, err=1, err_cnt=1, next legal word still at 0x104.
REQ-044 out_ready=0, three valid requests back-to-back -> in_ready drops after two accepts; raise out_ready -> words drain in order at 0x0, 0x4, 0x8.
REQ-045 300 illegal kinds (kind=15) -> err_cnt 255, err 1, out_valid never asserted.
REQ-046 base_load 0xFFFFFFFC, two ADDI requests -> addresses 0xFFFFFFFC then 0x00000000; assert reset with a word queued -> out_valid 0 immediately.
